// File: rtl/vrf_writeback.sv
// Writeback stage: buffers ALU results in an in-order FIFO and drains one per cycle
// into a 2**ADDR_W x DATA_W register file with two combinational read ports.
module vrf_writeback #(
    parameter int unsigned DEPTH  = 4,
    parameter int unsigned DATA_W = 64,
    parameter int unsigned ADDR_W = 5
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       wb_valid,
    output logic                       wb_ready,
    input  logic [ADDR_W+DATA_W-1:0]   wb_in,
    input  logic                       drain_hold,
    input  logic [ADDR_W-1:0]          rd_addr_a,
    input  logic [ADDR_W-1:0]          rd_addr_b,
    output logic [DATA_W-1:0]          rd_data_a,
    output logic [DATA_W-1:0]          rd_data_b,
    output logic                       rd_pend_a,
    output logic                       rd_pend_b,
    output logic [$clog2(DEPTH):0]     fifo_count
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam int unsigned NREG  = 2 ** ADDR_W;

    // wb_in is {dest_addr, data}: the big-endian bits [0:4] land in the top ADDR_W bits here
    logic [ADDR_W-1:0] in_addr;
    logic [DATA_W-1:0] in_data;
    assign in_addr = wb_in[ADDR_W+DATA_W-1:DATA_W];
    assign in_data = wb_in[DATA_W-1:0];

    logic [DATA_W-1:0] regs       [NREG];
    logic [ADDR_W-1:0] entry_addr [DEPTH];
    logic [DATA_W-1:0] entry_data [DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [CNT_W-1:0]  count;

    logic push;
    logic pop;

    assign wb_ready   = (count != CNT_W'(DEPTH));
    assign push       = wb_valid && wb_ready;
    assign pop        = (count != '0) && !drain_hold;
    assign fifo_count = count;

    // FIFO payload storage; validity is tracked by pointers/count, so no reset needed
    always_ff @(posedge clk) begin
        if (push && !reset) begin
            entry_addr[wr_ptr] <= in_addr;
            entry_data[wr_ptr] <= in_data;
        end
    end

    // Pointers, occupancy and register-file writes; reset flushes everything
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < NREG; i++) begin
                regs[i] <= '0;
            end
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                regs[entry_addr[rd_ptr]] <= entry_data[rd_ptr];
                rd_ptr                   <= rd_ptr + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    assign rd_data_a = regs[rd_addr_a];
    assign rd_data_b = regs[rd_addr_b];

    // Hazard flags: an entry is live when its distance from the head is below count
    logic [PTR_W-1:0] offset [DEPTH];
    always_comb begin
        rd_pend_a = 1'b0;
        rd_pend_b = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            offset[i] = PTR_W'(i) - rd_ptr;
            if (CNT_W'(offset[i]) < count) begin
                if (entry_addr[i] == rd_addr_a) rd_pend_a = 1'b1;
                if (entry_addr[i] == rd_addr_b) rd_pend_b = 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_vrf_writeback.sv
// Directed self-checking bench for vrf_writeback.
module tb_vrf_writeback;

    logic        clk;
    logic        reset;
    logic        wb_valid;
    logic        wb_ready;
    logic [68:0] wb_in;
    logic        drain_hold;
    logic [4:0]  rd_addr_a;
    logic [4:0]  rd_addr_b;
    logic [63:0] rd_data_a;
    logic [63:0] rd_data_b;
    logic        rd_pend_a;
    logic        rd_pend_b;
    logic [2:0]  fifo_count;

    int checks;
    int failures;

    vrf_writeback dut (
        .clk        (clk),
        .reset      (reset),
        .wb_valid   (wb_valid),
        .wb_ready   (wb_ready),
        .wb_in      (wb_in),
        .drain_hold (drain_hold),
        .rd_addr_a  (rd_addr_a),
        .rd_addr_b  (rd_addr_b),
        .rd_data_a  (rd_data_a),
        .rd_data_b  (rd_data_b),
        .rd_pend_a  (rd_pend_a),
        .rd_pend_b  (rd_pend_b),
        .fifo_count (fifo_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one rising edge; inputs change and outputs are sampled 1 time unit after it
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1; wb_valid = 1'b0; wb_in = '0; drain_hold = 1'b0;
        rd_addr_a = 5'd0; rd_addr_b = 5'd31;
        step(); step();
        reset = 1'b0;
        #1;
        checks++;
        if (fifo_count !== 3'd0) begin failures++; $display("FAIL reset_count got=%0d exp=0", fifo_count); end
        checks++;
        if (wb_ready !== 1'b1) begin failures++; $display("FAIL reset_ready got=%b exp=1", wb_ready); end
        checks++;
        if ({rd_pend_a, rd_pend_b} !== 2'b00) begin failures++; $display("FAIL reset_pend got=%b%b exp=00", rd_pend_a, rd_pend_b); end
        checks++;
        if (rd_data_a !== 64'd0 || rd_data_b !== 64'd0) begin
            failures++; $display("FAIL reset_data got a=%h b=%h exp=0", rd_data_a, rd_data_b);
        end
    endtask

    task automatic test_single();
        rd_addr_a = 5'd3;
        wb_valid = 1'b1; wb_in = {5'd3, 64'h0123_4567_89AB_CDEF};
        step();
        wb_valid = 1'b0;
        #1;
        checks++;
        if (rd_pend_a !== 1'b1 || fifo_count !== 3'd1) begin
            failures++; $display("FAIL single_edge1 got pend=%b cnt=%0d exp pend=1 cnt=1", rd_pend_a, fifo_count);
        end
        checks++;
        if (rd_data_a !== 64'd0) begin failures++; $display("FAIL single_nobypass got=%h exp=0", rd_data_a); end
        step();
        checks++;
        if (rd_data_a !== 64'h0123_4567_89AB_CDEF || rd_pend_a !== 1'b0 || fifo_count !== 3'd0) begin
            failures++;
            $display("FAIL single_edge2 got data=%h pend=%b cnt=%0d exp data=0123456789abcdef pend=0 cnt=0",
                     rd_data_a, rd_pend_a, fifo_count);
        end
    endtask

    task automatic test_full();
        drain_hold = 1'b1;
        wb_valid   = 1'b1;
        for (int i = 0; i < 5; i++) begin
            wb_in = {5'(20 + i), 64'(256 + i)};
            #1;
            checks++;
            if (wb_ready !== (i < 4)) begin failures++; $display("FAIL full_ready_%0d got=%b exp=%b", i, wb_ready, (i < 4)); end
            step();
            checks++;
            if (fifo_count !== 3'((i < 4) ? i + 1 : 4)) begin
                failures++; $display("FAIL full_count_%0d got=%0d exp=%0d", i, fifo_count, (i < 4) ? i + 1 : 4);
            end
        end
        wb_valid   = 1'b0;
        drain_hold = 1'b0;
        for (int k = 0; k < 4; k++) begin
            rd_addr_a = 5'(20 + k);
            step();
            checks++;
            if (rd_data_a !== 64'(256 + k) || fifo_count !== 3'(3 - k) || wb_ready !== 1'b1) begin
                failures++;
                $display("FAIL drain_%0d got data=%h cnt=%0d rdy=%b exp data=%h cnt=%0d rdy=1",
                         k, rd_data_a, fifo_count, wb_ready, 64'(256 + k), 3 - k);
            end
        end
        rd_addr_a = 5'd24;
        #1;
        checks++;
        if (rd_data_a !== 64'd0) begin failures++; $display("FAIL full_rejected got=%h exp=0", rd_data_a); end
    endtask

    task automatic test_same_addr();
        drain_hold = 1'b1;
        rd_addr_a  = 5'd7;
        wb_valid   = 1'b1;
        wb_in = {5'd7, 64'hA}; step();
        wb_in = {5'd7, 64'hB}; step();
        wb_valid   = 1'b0;
        drain_hold = 1'b0;
        step();
        checks++;
        if (rd_pend_a !== 1'b1 || rd_data_a !== 64'hA) begin
            failures++; $display("FAIL same_first got pend=%b data=%h exp pend=1 data=a", rd_pend_a, rd_data_a);
        end
        step();
        checks++;
        if (rd_pend_a !== 1'b0 || rd_data_a !== 64'hB) begin
            failures++; $display("FAIL same_second got pend=%b data=%h exp pend=0 data=b", rd_pend_a, rd_data_a);
        end
    endtask

    task automatic test_back_to_back();
        drain_hold = 1'b0;
        wb_valid   = 1'b1;
        for (int i = 0; i < 10; i++) begin
            wb_in = {5'(i), 64'(i + 1)};
            step();
            checks++;
            if (fifo_count !== 3'd1) begin failures++; $display("FAIL b2b_count_%0d got=%0d exp=1", i, fifo_count); end
        end
        wb_valid = 1'b0;
        step();
        checks++;
        if (fifo_count !== 3'd0) begin failures++; $display("FAIL b2b_empty got=%0d exp=0", fifo_count); end
        for (int i = 0; i < 10; i++) begin
            rd_addr_a = 5'(i);
            rd_addr_b = 5'(9 - i);
            #1;
            checks++;
            if (rd_data_a !== 64'(i + 1) || rd_data_b !== 64'(10 - i)) begin
                failures++;
                $display("FAIL b2b_reg_%0d got a=%h b=%h exp a=%h b=%h", i, rd_data_a, rd_data_b, 64'(i + 1), 64'(10 - i));
            end
        end
    endtask

    task automatic test_reset_flush();
        logic bad;
        drain_hold = 1'b1;
        wb_valid   = 1'b1;
        for (int i = 0; i < 3; i++) begin
            wb_in = {5'(2 + i), 64'hDEAD_0000 + 64'(i)};
            step();
        end
        wb_valid = 1'b0;
        // Release drain together with reset: reset must win over the pop
        drain_hold = 1'b0;
        reset      = 1'b1;
        rd_addr_a  = 5'd2;
        rd_addr_b  = 5'd3;
        step();
        reset = 1'b0;
        #1;
        checks++;
        if (fifo_count !== 3'd0 || {rd_pend_a, rd_pend_b} !== 2'b00 || wb_ready !== 1'b1) begin
            failures++;
            $display("FAIL flush_state got cnt=%0d pend=%b%b rdy=%b exp cnt=0 pend=00 rdy=1",
                     fifo_count, rd_pend_a, rd_pend_b, wb_ready);
        end
        step(); step(); step();
        bad = 1'b0;
        for (int r = 0; r < 32; r++) begin
            rd_addr_a = 5'(r);
            #1;
            if (rd_data_a !== 64'd0) bad = 1'b1;
        end
        checks++;
        if (bad !== 1'b0) begin failures++; $display("FAIL flush_regs got nonzero register exp all 0"); end
    endtask

    task automatic test_read_ports();
        drain_hold = 1'b1;
        rd_addr_a  = 5'd12;
        rd_addr_b  = 5'd12;
        wb_valid   = 1'b1;
        wb_in = {5'd12, 64'h1234_5678_9ABC_DEF0};
        step();
        wb_valid = 1'b0;
        checks++;
        if ({rd_pend_a, rd_pend_b} !== 2'b11) begin failures++; $display("FAIL ports_both got=%b%b exp=11", rd_pend_a, rd_pend_b); end
        rd_addr_b = 5'd13;
        #1;
        checks++;
        if ({rd_pend_a, rd_pend_b} !== 2'b10) begin failures++; $display("FAIL ports_split got=%b%b exp=10", rd_pend_a, rd_pend_b); end
        drain_hold = 1'b0;
        step();
        checks++;
        if (rd_data_a !== 64'h1234_5678_9ABC_DEF0 || rd_pend_a !== 1'b0 || rd_data_b !== 64'd0) begin
            failures++;
            $display("FAIL ports_write got a=%h pend=%b b=%h exp a=123456789abcdef0 pend=0 b=0", rd_data_a, rd_pend_a, rd_data_b);
        end
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        test_reset();
        test_single();
        test_full();
        test_same_addr();
        test_back_to_back();
        test_reset_flush();
        test_read_ports();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
